// File: rtl/rv_c_pkg.sv
// Shared constants and types for the RV C-extension stack-pointer load/store unit.
package rv_c_pkg;

  localparam logic [1:0] C_OP2   = 2'b10;
  localparam logic [2:0] F3_LWSP = 3'b010;
  localparam logic [2:0] F3_LDSP = 3'b011;
  localparam logic [2:0] F3_SWSP = 3'b110;
  localparam logic [2:0] F3_SDSP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_ILLEGAL  = 2'd2,
    EXC_FAULT    = 2'd3
  } exc_e;

  typedef enum logic [1:0] {
    OP_LW,
    OP_SW,
    OP_LD,
    OP_SD
  } op_e;

  function automatic logic op_is_load(input op_e op);
    return (op == OP_LW) || (op == OP_LD);
  endfunction

  function automatic logic op_is_dword(input op_e op);
    return (op == OP_LD) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/rv_c_sp_lsu_if.sv
// Instruction, register-file and RAM handshake bundle of the sp-relative LSU.
interface rv_c_sp_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
);
  logic              iVALID;
  logic              oREADY;
  logic [15:0]       iIR;
  logic [4:0]        oRS1;
  logic [4:0]        oRS2;
  logic [XLEN-1:0]   iRS1;
  logic [XLEN-1:0]   iRS2;
  logic [4:0]        oRD;
  logic [XLEN-1:0]   oRD_DATA;
  logic              oRD_WE;
  logic              oDONE;
  logic [1:0]        oEXC;
  logic              oRAM_CE;
  logic              oRAM_RD;
  logic              oRAM_WR;
  logic [ADDR_W-1:0] oRAM_ADDR;
  logic [31:0]       oRAM_DATA;
  logic [31:0]       iRAM_DATA;
  logic              iRAM_ACK;

  modport master (
    input  iVALID, iIR, iRS1, iRS2, iRAM_DATA, iRAM_ACK,
    output oREADY, oRS1, oRS2, oRD, oRD_DATA, oRD_WE, oDONE, oEXC,
           oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
  );

  modport slave (
    output iVALID, iIR, iRS1, iRS2, iRAM_DATA, iRAM_ACK,
    input  oREADY, oRS1, oRS2, oRD, oRD_DATA, oRD_WE, oDONE, oEXC,
           oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA
  );
endinterface

// File: rtl/rv_c_sp_decode.sv
// Combinational decode of c.lwsp/c.swsp/c.ldsp/c.sdsp into op kind, offset, rd and illegal flag.
module rv_c_sp_decode
  import rv_c_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [15:0] i_ir,
  output op_e         o_op,
  output logic [8:0]  o_uimm,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  always_comb begin
    // NOTE: every output is defaulted first so no path through the case can infer a latch.
    o_op      = OP_LW;
    o_uimm    = '0;
    o_rd      = i_ir[11:7];
    o_illegal = 1'b1;
    if (i_ir[1:0] == C_OP2) begin
      case (i_ir[15:13])
        F3_SWSP: begin
          o_op      = OP_SW;
          o_uimm    = {1'b0, i_ir[8:7], i_ir[12:9], 2'b00};
          o_rd      = '0;
          o_illegal = 1'b0;
        end
        F3_LWSP: begin
          o_op      = OP_LW;
          o_uimm    = {1'b0, i_ir[3:2], i_ir[12], i_ir[6:4], 2'b00};
          o_illegal = (i_ir[11:7] == 5'd0);
        end
        F3_SDSP: begin
          o_op      = OP_SD;
          o_uimm    = {i_ir[9:7], i_ir[12:10], 3'b000};
          o_rd      = '0;
          o_illegal = (XLEN != 64);
        end
        F3_LDSP: begin
          o_op      = OP_LD;
          o_uimm    = {i_ir[4:2], i_ir[12], i_ir[6:5], 3'b000};
          o_illegal = (XLEN != 64) || (i_ir[11:7] == 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rv_c_sp_lsu.sv
// Multi-cycle sp-relative load/store unit driving a 32-bit word RAM; doubleword ops take two beats.
// Optional ack watchdog enabled by defining RV_C_SP_LSU_TIMEOUT_EN.
module rv_c_sp_lsu
  import rv_c_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          iCLK,
  input logic          iRST_N,
  rv_c_sp_lsu_if.master bus
);

  op_e               w_op;
  logic [8:0]        w_uimm;
  logic [4:0]        w_rd;
  logic              w_illegal;
  logic [XLEN-1:0]   w_byte_addr;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_beat_ack;
  logic              w_timeout;
  logic              w_tmo_hit;
  logic [63:0]       w_result;
  state_e            w_state_nxt;

  state_e            r_state;
  op_e               r_op;
  exc_e              r_exc;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_rd;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;

  rv_c_sp_decode #(.XLEN(XLEN)) u_decode (
    .i_ir      (bus.iIR),
    .o_op      (w_op),
    .o_uimm    (w_uimm),
    .o_rd      (w_rd),
    .o_illegal (w_illegal)
  );

  assign w_byte_addr  = bus.iRS1 + XLEN'(w_uimm);
  assign w_word_addr  = ADDR_W'(w_byte_addr >> 2);
  assign w_misaligned = op_is_dword(w_op) ? (w_byte_addr[2:0] != 3'd0)
                                          : (w_byte_addr[1:0] != 2'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_beat_ack  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.iVALID) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_illegal || w_misaligned) ? ST_DONE : ST_BEAT0;
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (bus.iRAM_ACK) begin
          w_beat_ack  = 1'b1;
          w_state_nxt = (r_state == ST_BEAT0 && op_is_dword(r_op)) ? ST_BEAT1 : ST_DONE;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples the values from before this edge.
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_op    <= OP_LW;
      r_exc   <= EXC_NONE;
      r_addr  <= '0;
      r_rd    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op;
        r_addr  <= w_word_addr;
        r_rd    <= w_rd;
        r_wdata <= 64'(bus.iRS2);
        r_exc   <= w_illegal ? EXC_ILLEGAL : (w_misaligned ? EXC_MISALIGN : EXC_NONE);
      end
      if (w_beat_ack) begin
        if (r_state == ST_BEAT1) r_rdata[63:32] <= bus.iRAM_DATA;
        else                     r_rdata[31:0]  <= bus.iRAM_DATA;
      end
      if (w_timeout) r_exc <= EXC_FAULT;
    end
  end

`ifdef RV_C_SP_LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] r_tmo_cnt;

  // Any state change restarts the count, so each beat gets a full window.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tmo_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_BEAT0 || r_state == ST_BEAT1) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // Word loads sign-extend into the upper half; harmless truncation when XLEN=32.
  assign w_result = op_is_dword(r_op) ? r_rdata : {{32{r_rdata[31]}}, r_rdata[31:0]};

  assign bus.oREADY    = (r_state == ST_IDLE);
  assign bus.oRS1      = 5'h2;
  assign bus.oRS2      = bus.iIR[6:2];
  assign bus.oRAM_CE   = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
  assign bus.oRAM_RD   = bus.oRAM_CE && op_is_load(r_op);
  assign bus.oRAM_WR   = bus.oRAM_CE && !op_is_load(r_op);
  assign bus.oRAM_ADDR = (r_state == ST_BEAT1) ? r_addr + ADDR_W'(1) : r_addr;
  assign bus.oRAM_DATA = (r_state == ST_BEAT1) ? r_wdata[63:32] : r_wdata[31:0];
  assign bus.oDONE     = (r_state == ST_DONE);
  assign bus.oEXC      = bus.oDONE ? r_exc : EXC_NONE;
  assign bus.oRD_WE    = bus.oDONE && op_is_load(r_op) && (r_exc == EXC_NONE);
  assign bus.oRD       = r_rd;
  assign bus.oRD_DATA  = XLEN'(w_result);

endmodule

// File: tb/tb_rv_c_sp_lsu.sv
// Randomised self-checking bench for rv_c_sp_lsu (XLEN=64) against an encode-side reference model.
module tb_rv_c_sp_lsu;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 8;
  localparam int TMO    = 16;

  typedef enum int {K_LW, K_SW, K_LD, K_SD, K_ILL} kind_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  rv_c_sp_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  rv_c_sp_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Builds the 16-bit instruction from the offset/register fields.
  function automatic logic [15:0] encode(input kind_e k, input logic [8:0] u, input logic [4:0] r);
    logic [15:0] ir;
    int unsigned v;
    ir = '0;
    case (k)
      K_SW: begin ir[15:13] = 3'b110; ir[12:9] = u[5:2]; ir[8:7] = u[7:6]; ir[6:2] = r; end
      K_LW: begin ir[15:13] = 3'b010; ir[12] = u[5]; ir[11:7] = r; ir[6:4] = u[4:2]; ir[3:2] = u[7:6]; end
      K_SD: begin ir[15:13] = 3'b111; ir[12:10] = u[5:3]; ir[9:7] = u[8:6]; ir[6:2] = r; end
      K_LD: begin ir[15:13] = 3'b011; ir[12] = u[5]; ir[11:7] = r; ir[6:5] = u[4:3]; ir[4:2] = u[8:6]; end
      default: begin
        ir = 16'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          v = $urandom_range(0, 2);
          ir[1:0] = (v == 2) ? 2'b11 : 2'(v);
        end else begin
          ir[14]  = 1'b0;
          ir[1:0] = 2'b10;
        end
      end
    endcase
    if (k != K_ILL) ir[1:0] = 2'b10;
    return ir;
  endfunction

  task automatic run_op(input kind_e k, input logic [8:0] u, input logic [4:0] r,
                        input logic [63:0] sp, input logic [63:0] rs2,
                        input int d0, input int d1, input bit noise);
    logic [15:0] ir;
    logic [63:0] addr;
    logic [63:0] exp_res;
    logic [1:0]  exc;
    bit          is_load;
    bit          is_d;
    int unsigned w0;
    int unsigned w1;
    ir      = encode(k, u, r);
    is_load = (k == K_LW) || (k == K_LD);
    is_d    = (k == K_LD) || (k == K_SD);
    addr    = sp + 64'(u);
    if (k == K_ILL || (is_load && r == 5'd0)) exc = 2'd2;
    else if (addr % (is_d ? 64'd8 : 64'd4) != 64'd0) exc = 2'd1;
    else exc = 2'd0;
    w0 = 32'((addr >> 2) % 256);
    w1 = (w0 + 1) % 256;

    bus.iIR    = ir;
    bus.iRS1   = sp;
    bus.iRS2   = rs2;
    bus.iVALID = 1'b1;
    #1;
    check("idle_ready", 64'(bus.oREADY), 64'd1);
    check("rs2_index", 64'(bus.oRS2), 64'(ir[6:2]));
    @(posedge clk); #1;
    bus.iVALID = noise;
    if (noise) begin
      bus.iIR  = 16'($urandom);
      bus.iRS1 = {$urandom, $urandom};
    end

    if (exc != 2'd0) begin
      check("exc_ce", 64'(bus.oRAM_CE), 64'd0);
      check("exc_done", 64'(bus.oDONE), 64'd1);
      check("exc_code", 64'(bus.oEXC), 64'(exc));
      check("exc_rd_we", 64'(bus.oRD_WE), 64'd0);
    end else begin
      for (int b = 0; b < (is_d ? 2 : 1); b++) begin
        int          dly;
        int unsigned wa;
        logic [31:0] wd;
        dly = (b == 1) ? d1 : d0;
        wa  = (b == 1) ? w1 : w0;
        wd  = (b == 1) ? rs2[63:32] : rs2[31:0];
        for (int c = 0; c <= dly; c++) begin
          check("beat_ce", 64'(bus.oRAM_CE), 64'd1);
          check("beat_rd", 64'(bus.oRAM_RD), 64'(is_load));
          check("beat_wr", 64'(bus.oRAM_WR), 64'(!is_load));
          check("beat_addr", 64'(bus.oRAM_ADDR), 64'(wa));
          if (!is_load) check("beat_data", 64'(bus.oRAM_DATA), 64'(wd));
          if (c == dly) begin
            bus.iRAM_ACK = 1'b1;
            if (is_load) bus.iRAM_DATA = mem[wa];
            else         mem[wa] = wd;
          end else begin
            bus.iRAM_DATA = $urandom;
          end
          @(posedge clk); #1;
          bus.iRAM_ACK = 1'b0;
        end
      end
      exp_res = (k == K_LD) ? {mem[w1], mem[w0]} : {{32{mem[w0][31]}}, mem[w0]};
      check("done_pulse", 64'(bus.oDONE), 64'd1);
      check("done_exc", 64'(bus.oEXC), 64'd0);
      check("done_rd_we", 64'(bus.oRD_WE), 64'(is_load));
      if (is_load) begin
        check("done_rd", 64'(bus.oRD), 64'(r));
        check("done_rd_data", bus.oRD_DATA, exp_res);
      end
    end
    bus.iVALID = 1'b0;
    @(posedge clk); #1;
    check("post_done", 64'(bus.oDONE), 64'd0);
    check("post_ready", 64'(bus.oREADY), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    bus.iVALID    = 1'b0;
    bus.iIR       = '0;
    bus.iRS1      = '0;
    bus.iRS2      = '0;
    bus.iRAM_DATA = '0;
    bus.iRAM_ACK  = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(bus.oREADY), 64'd1);
    check("rst_rs1", 64'(bus.oRS1), 64'h2);
    check("rst_ce", 64'(bus.oRAM_CE), 64'd0);
    check("rst_rd", 64'(bus.oRAM_RD), 64'd0);
    check("rst_wr", 64'(bus.oRAM_WR), 64'd0);
    check("rst_addr", 64'(bus.oRAM_ADDR), 64'd0);
    check("rst_data", 64'(bus.oRAM_DATA), 64'd0);
    check("rst_done", 64'(bus.oDONE), 64'd0);
    check("rst_rd_we", 64'(bus.oRD_WE), 64'd0);
    check("rst_exc", 64'(bus.oEXC), 64'd0);
    check("rst_rd_idx", 64'(bus.oRD), 64'd0);
    check("rst_rd_data", bus.oRD_DATA, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray ack while idle must not start anything.
    bus.iRAM_ACK = 1'b1;
    @(posedge clk); #1;
    bus.iRAM_ACK = 1'b0;
    check("idle_ack_done", 64'(bus.oDONE), 64'd0);
    check("idle_ack_ce", 64'(bus.oRAM_CE), 64'd0);

    mem[8'h12] = 32'h12345678;
    mem[8'h20] = 32'h80000001;
    run_op(K_SW, 9'd0, 5'd1, 64'h100, 64'hDEADBEEF, 0, 0, 1'b0);
    run_op(K_LW, 9'd8, 5'd8, 64'h40, 64'h0, 3, 0, 1'b0);
    run_op(K_SD, 9'd8, 5'd3, 64'h100, 64'h11112222_33334444, 0, 0, 1'b0);
    run_op(K_LD, 9'd8, 5'd9, 64'h100, 64'h0, 1, 2, 1'b1);
    run_op(K_LW, 9'd0, 5'd7, 64'h80, 64'h0, 0, 0, 1'b0);
    run_op(K_LW, 9'd0, 5'd5, 64'h102, 64'h0, 0, 0, 1'b0);
    run_op(K_LW, 9'd4, 5'd0, 64'h100, 64'h0, 0, 0, 1'b0);
    run_op(K_LD, 9'd8, 5'd4, 64'h104, 64'h0, 0, 0, 1'b0);
    run_op(K_SD, 9'd0, 5'd6, 64'h3FC, 64'hCAFEF00D_0BADBEEF, 2, 0, 1'b0);
    run_op(K_ILL, 9'd0, 5'd0, 64'h100, 64'h0, 0, 0, 1'b1);

    // Reset in the middle of BEAT0: CE must fall immediately and no completion follows.
    bus.iIR    = encode(K_SW, 9'd4, 5'd2);
    bus.iRS1   = 64'h100;
    bus.iRS2   = 64'h55;
    bus.iVALID = 1'b1;
    @(posedge clk); #1;
    bus.iVALID = 1'b0;
    check("mid_rst_ce_before", 64'(bus.oRAM_CE), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ce", 64'(bus.oRAM_CE), 64'd0);
    check("mid_rst_wr", 64'(bus.oRAM_WR), 64'd0);
    check("mid_rst_ready", 64'(bus.oREADY), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", 64'(bus.oDONE), 64'd0);
      check("post_rst_ready", 64'(bus.oREADY), 64'd1);
    end

`ifdef RV_C_SP_LSU_TIMEOUT_EN
    begin
      int n;
      bus.iIR    = encode(K_SW, 9'd0, 5'd1);
      bus.iRS1   = 64'h200;
      bus.iVALID = 1'b1;
      @(posedge clk); #1;
      bus.iVALID = 1'b0;
      n = 0;
      while (bus.oRAM_CE && n < 40) begin
        n++;
        @(posedge clk); #1;
      end
      check("tmo_ce_cycles", 64'(n), 64'(TMO));
      check("tmo_done", 64'(bus.oDONE), 64'd1);
      check("tmo_exc", 64'(bus.oEXC), 64'd3);
      check("tmo_rd_we", 64'(bus.oRD_WE), 64'd0);
      @(posedge clk); #1;
      check("tmo_ready", 64'(bus.oREADY), 64'd1);
    end
`endif

    repeat (60) begin
      kind_e       k;
      logic [8:0]  u;
      logic [63:0] sp;
      k  = kind_e'($urandom_range(0, 4));
      u  = (k == K_LD || k == K_SD) ? 9'($urandom_range(0, 63) * 8) : 9'($urandom_range(0, 63) * 4);
      sp = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) sp[2:0] = 3'b000;
      run_op(k, u, 5'($urandom), sp, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_c_sp_lsu.md
Name: rv_c_sp_lsu

Overview:
- Multi-cycle load/store unit for RV C-extension stack-pointer-relative accesses: c.lwsp, c.swsp, plus c.ldsp/c.sdsp when XLEN=64.
- Sits in the rv32c/rv64c ALU path between the compressed decoder and the 32-bit word RAM.
- Decodes and latches one instruction, then drives a ready/ack handshake to RAM.
- Splits 64-bit accesses into two 32-bit beats, returns load data for register write-back, and flags misaligned or illegal encodings.

Parameters:
- XLEN, 32, register width; legal values 32 or 64 only; 64 enables the doubleword ops.
- ADDR_W, 8, RAM word-address width.
- TIMEOUT_CYCLES, 16, ack watchdog limit; used only when the optional feature is enabled.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iVALID  in  1  instruction present on iIR.
- oREADY  out  1  unit idle; accepts iVALID.
- iIR  in  16  compressed instruction.
- oRS1  out  5  constant 5'h2 (sp).
- oRS2  out  5  iIR[6:2].
- iRS1  in  XLEN  sp value.
- iRS2  in  XLEN  store source value.
- oRD  out  5  load destination.
- oRD_DATA  out  XLEN  load result.
- oRD_WE  out  1  one-cycle write-back strobe.
- oDONE  out  1  one-cycle completion pulse, for loads and stores.
- oEXC  out  2  exception code: 0 none, 1 misaligned, 2 illegal, 3 fault.
- oRAM_CE  out  1  RAM chip enable.
- oRAM_RD  out  1  RAM read.
- oRAM_WR  out  1  RAM write.
- oRAM_ADDR  out  ADDR_W  word address.
- oRAM_DATA  out  32  write data.
- iRAM_DATA  in  32  read data.
- iRAM_ACK  in  1  beat complete.

Behaviour:
- Reset: all outputs 0 except oREADY=1 and oRS1=5'h2. FSM goes to IDLE; latched registers cleared.
- Reset mid-access drops CE/RD/WR the same instant (async) and produces no oDONE.
- Decode when op=2'b10:
  - funct3 110 = c.swsp: uimm = {ir[8:7], ir[12:9], 2'b00}.
  - funct3 010 = c.lwsp: uimm = {ir[3:2], ir[12], ir[6:4], 2'b00}; rd = ir[11:7].
  - funct3 111 = c.sdsp: uimm = {ir[9:7], ir[12:10], 3'b000}.
  - funct3 011 = c.ldsp: uimm = {ir[4:2], ir[12], ir[6:5], 3'b000}.
  - Any other op/funct3, c.lwsp/c.ldsp with rd=0, or a D-op with XLEN=32 → illegal.
- Address: byte address = iRS1 + zero-extended uimm, XLEN-bit wrap-around. Word address = byte address >> 2, truncated to ADDR_W.
- Misaligned: byte address[1:0] != 0 for W-ops, byte address[2:0] != 0 for D-ops.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - Accept when iVALID && oREADY.
  - Latch the decoded op, address, rd and store data (iRS2).
  - Illegal or misaligned → DONE with oEXC set and no RAM access.
  - Otherwise → BEAT0.
- BEAT0/BEAT1:
  - oRAM_CE=1, plus RD for loads or WR for stores.
  - Address and data held stable until iRAM_ACK is sampled high.
  - BEAT0 uses the word address and data bits [31:0].
  - BEAT1 (D-ops only) uses word address+1 (wraps within ADDR_W) and data bits [63:32].
  - On ack: W-op → DONE; D-op BEAT0 → BEAT1; BEAT1 → DONE.
  - Load data is captured on each ack.
  - ack in the first cycle of a beat is legal: one cycle per beat.
- DONE:
  - oDONE=1 for one cycle; oRD_WE=1 for successful loads only.
  - oRD_DATA = captured word (D-op) or sign-extended word when XLEN=64 and W-op.
  - Returns to IDLE.
- oREADY=1 only in IDLE. iVALID outside IDLE is ignored.
- iRAM_ACK outside BEAT states is ignored.
- Latency with zero-wait RAM: accept at cycle N; CE from N+1; W-op oDONE at N+2; D-op oDONE at N+3.

Optional Feature:
- Macro RV_C_SP_LSU_TIMEOUT_EN.
- Enabled:
  - Per-beat counter clears on beat entry.
  - Reaching TIMEOUT_CYCLES without ack deasserts CE and goes to DONE with oEXC=3; no write-back.
- Disabled: no counter; the unit waits for ack indefinitely and oEXC never equals 3.

Decomposition:
- Package rv_c_pkg holds:
  - op/funct3 constants (C_OP2, F3_LWSP, F3_SWSP, F3_LDSP, F3_SDSP);
  - the FSM state typedef;
  - oEXC encodings.
- Sub-module rv_c_sp_decode: combinational decode producing op kind, uimm, rd and illegal; the FSM stays in the parent.

Test Plan:
- c.swsp 0xC006 (rs2=x1, uimm=0), sp=0x100, x1=0xDEADBEEF, ack in the first cycle of the beat → WR with ADDR=0x40, DATA=0xDEADBEEF; oDONE at N+2; oRD_WE=0.
- c.lwsp x8 uimm=8, sp=0x40, ack delayed 3 cycles, iRAM_DATA=0x12345678 → ADDR=0x12 held for 4 cycles; oRD=8, oRD_DATA=0x12345678, oRD_WE pulse.
- XLEN=64 c.sdsp uimm=8, sp=0x100, rs2=0x11112222_33334444 → beat ADDR 0x42 data 0x33334444, then ADDR 0x43 data 0x11112222; single oDONE.
- c.lwsp with sp=0x102 → oEXC=1, no CE; c.lwsp with rd=0 → oEXC=2.
- Reset asserted during BEAT0 → CE=0 immediately, oREADY=1 after release, no oDONE.
- With RV_C_SP_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, ack never arrives → CE drops after 16 cycles; oEXC=3, oDONE pulse.
